seven_segment_scanner: RTL and testbench



---
 rtl/seven_seg_pkg.sv | 17 +
 rtl/seven_segment_scanner.sv | 92 +++++++++
 tb/tb_seven_segment_scanner.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment display path (hgfedcba, 0 = lit)
// and the counter-width helper used by the scanner.
package seven_seg_pkg;

   localparam logic [7:0] SEG_BLANK   = 8'hFF;
   localparam logic [7:0] GLYPH_C     = 8'b1100_0110;
   localparam logic [7:0] GLYPH_H     = 8'b1000_1011;
   localparam logic [7:0] GLYPH_I     = 8'b1100_1111;
   localparam logic [7:0] GLYPH_P     = 8'b1000_1100;
   localparam logic [7:0] GLYPH_BLANK = SEG_BLANK;

   // Bits needed to count 0..n-1; never below 1 so degenerate sizes still elaborate.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed seven-segment driver: snapshots a frame of segment codes,
// scans one digit per slot with leading blanking and 16-level PWM brightness.
module seven_segment_scanner
   import seven_seg_pkg::*;
#(
   parameter int N_DIGITS         = 6,
   parameter int DIGIT_PERIOD     = 4096,
   parameter int BLANK_CYCLES     = 64,
   parameter int SEG_ACTIVE_LOW   = 1,
   parameter int DIGIT_ACTIVE_LOW = 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [N_DIGITS*8-1:0] segs_in,
   input  logic                  enable,
   input  logic [3:0]            brightness,
   output logic [7:0]            seg,
   output logic [N_DIGITS-1:0]   digit_sel,
   output logic                  frame_start
);

   localparam int CW = cnt_width(DIGIT_PERIOD);
   localparam int IW = cnt_width(N_DIGITS);

   localparam logic [CW-1:0]       C_BLANK  = CW'(BLANK_CYCLES);
   localparam logic [CW-1:0]       C_LAST   = CW'(DIGIT_PERIOD - 1);
   localparam logic [IW-1:0]       IDX_LAST = IW'(N_DIGITS - 1);
   localparam logic [7:0]          SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? SEG_BLANK : ~SEG_BLANK;
   localparam logic [N_DIGITS-1:0] DSEL_OFF = (DIGIT_ACTIVE_LOW != 0) ? '1 : '0;

   logic [CW-1:0]         c;
   logic [IW-1:0]         idx;
   logic [N_DIGITS*8-1:0] snap;
   logic [3:0]            bq;

   logic                  capture;
   logic                  drive;
   logic [7:0]            seg_next;
   logic [N_DIGITS-1:0]   sel_next;

   // seg_next/sel_next are in the internal 0-lit / 1-selected sense;
   // polarity is applied only when loading the output registers.
   always_comb begin
      capture  = enable && (c == '0) && (idx == '0);
      drive    = enable && (c >= C_BLANK) && (c[3:0] <= bq);
      seg_next = SEG_BLANK;
      sel_next = '0;
      if (drive) begin
         for (int i = 0; i < N_DIGITS; i++) begin
            if (idx == IW'(i)) begin
               seg_next    = snap[i*8 +: 8];
               sel_next[i] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         c           <= '0;
         idx         <= '0;
         bq          <= '0;
         snap        <= {N_DIGITS{SEG_BLANK}};
         seg         <= SEG_OFF;
         digit_sel   <= DSEL_OFF;
         frame_start <= 1'b0;
      end else if (!enable) begin
         c           <= '0;
         idx         <= '0;
         bq          <= '0;
         seg         <= SEG_OFF;
         digit_sel   <= DSEL_OFF;
         frame_start <= 1'b0;
      end else begin
         // DIGIT_PERIOD is a power of two, so c wraps to 0 on its own.
         c <= c + CW'(1);
         if (c == C_LAST) begin
            idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
         end
         if (c == '0) begin
            bq <= brightness;
         end
         if (capture) begin
            snap <= segs_in;
         end
         frame_start <= capture;
         seg         <= (SEG_ACTIVE_LOW != 0) ? seg_next : ~seg_next;
         digit_sel   <= (DIGIT_ACTIVE_LOW != 0) ? ~sel_next : sel_next;
      end
   end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Bench for seven_segment_scanner: probe table, hand-written corner sequences,
// and randomized stimulus checked every cycle against a cycle-count model.
module tb_seven_segment_scanner;

   localparam int N     = 6;
   localparam int P     = 32;
   localparam int B     = 4;
   localparam int FRAME = N * P;

   localparam logic [7:0] G_C  = 8'b1100_0110;
   localparam logic [7:0] G_H  = 8'b1000_1011;
   localparam logic [7:0] G_I  = 8'b1100_1111;
   localparam logic [7:0] G_P  = 8'b1000_1100;
   localparam logic [7:0] G_BL = 8'hFF;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          enable = 1'b0;
   logic [3:0]    brightness = 4'd15;
   logic [47:0]   segs_in = '1;
   logic [47:0]   segs2 = '1;
   logic [7:0]    seg, seg2;
   logic [5:0]    dsel, dsel2;
   logic          fs, fs2;

   seven_segment_scanner #(
      .N_DIGITS(N), .DIGIT_PERIOD(P), .BLANK_CYCLES(B),
      .SEG_ACTIVE_LOW(1), .DIGIT_ACTIVE_LOW(1)
   ) u_dut (
      .clk(clk), .reset_n(reset_n), .segs_in(segs_in), .enable(enable),
      .brightness(brightness), .seg(seg), .digit_sel(dsel), .frame_start(fs)
   );

   seven_segment_scanner #(
      .N_DIGITS(N), .DIGIT_PERIOD(P), .BLANK_CYCLES(B),
      .SEG_ACTIVE_LOW(0), .DIGIT_ACTIVE_LOW(0)
   ) u_pol (
      .clk(clk), .reset_n(reset_n), .segs_in(segs2), .enable(enable),
      .brightness(brightness), .seg(seg2), .digit_sel(dsel2), .frame_start(fs2)
   );

   // clock
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: position in the scan is derived purely from how many
   // enabled edges have elapsed since scanning (re)started.
   int          run_t = 0;
   logic [47:0] m_snap = '1;
   int          m_bq = 0;
   logic [7:0]  e_seg;
   logic [5:0]  e_dsel;
   logic        e_fs;

   task automatic step();
      @(posedge clk);
      if (!reset_n || !enable) begin
         if (!reset_n) m_snap = '1;
         run_t  = 0;
         e_seg  = 8'hFF;
         e_dsel = 6'h3F;
         e_fs   = 1'b0;
      end else begin
         int c;
         int idx;
         bit drv;
         c    = run_t % P;
         idx  = (run_t / P) % N;
         e_fs = ((run_t % FRAME) == 0);
         if (e_fs) m_snap = segs_in;
         if (c == 0) m_bq = int'(brightness);
         drv    = (c >= B) && ((c % 16) <= m_bq);
         e_seg  = drv ? m_snap[idx*8 +: 8] : 8'hFF;
         e_dsel = drv ? ~(6'b1 << idx) : 6'h3F;
         run_t++;
      end
      #1;
      check("model_seg", 48'(seg), 48'(e_seg));
      check("model_digit_sel", 48'(dsel), 48'(e_dsel));
      check("model_frame_start", 48'(fs), 48'(e_fs));
   endtask

   task automatic restart();
      enable = 1'b0;
      step();
      enable = 1'b1;
   endtask

   typedef struct {
      int         t;
      logic [7:0] seg;
      logic [5:0] dsel;
      logic       fs;
   } probe_t;

   probe_t tbl [14];
   int     cnt;
   int     p;

   initial begin
      tbl[0]  = '{0,   8'hFF, 6'h3F, 1'b1};
      tbl[1]  = '{1,   8'hFF, 6'h3F, 1'b0};
      tbl[2]  = '{3,   8'hFF, 6'h3F, 1'b0};
      tbl[3]  = '{4,   8'hFF, 6'h3E, 1'b0};
      tbl[4]  = '{31,  8'hFF, 6'h3E, 1'b0};
      tbl[5]  = '{32,  8'hFF, 6'h3F, 1'b0};
      tbl[6]  = '{36,  8'hFF, 6'h3D, 1'b0};
      tbl[7]  = '{68,  G_P,   6'h3B, 1'b0};
      tbl[8]  = '{100, G_I,   6'h37, 1'b0};
      tbl[9]  = '{132, G_H,   6'h2F, 1'b0};
      tbl[10] = '{164, G_C,   6'h1F, 1'b0};
      tbl[11] = '{191, G_C,   6'h1F, 1'b0};
      tbl[12] = '{192, 8'hFF, 6'h3F, 1'b1};
      tbl[13] = '{196, 8'hFF, 6'h3E, 1'b0};

      // Reset held with enable already high
      enable     = 1'b1;
      brightness = 4'd15;
      segs_in    = {G_C, G_H, G_I, G_P, G_BL, G_BL};
      segs2      = {G_BL, G_BL, G_BL, G_BL, G_BL, 8'b1100_1111};
      for (int k = 0; k < 3; k++) step();
      check("reset_seg", 48'(seg), 48'(8'hFF));
      check("reset_digit_sel", 48'(dsel), 48'(6'h3F));
      check("reset_frame_start", 48'(fs), 48'(1'b0));
      check("pol_reset_seg", 48'(seg2), 48'(8'h00));
      check("pol_reset_digit_sel", 48'(dsel2), 48'(6'h00));

      // Full brightness frame, probe table
      reset_n = 1'b1;
      p = 0;
      for (int t = 0; t <= 200; t++) begin
         step();
         if (p < 14 && tbl[p].t == t) begin
            check($sformatf("tbl%0d_seg", p), 48'(seg), 48'(tbl[p].seg));
            check($sformatf("tbl%0d_digit_sel", p), 48'(dsel), 48'(tbl[p].dsel));
            check($sformatf("tbl%0d_frame_start", p), 48'(fs), 48'(tbl[p].fs));
            p++;
         end
         if (t == 4) begin
            check("pol_drive_seg", 48'(seg2), 48'(8'b0011_0000));
            check("pol_drive_digit_sel", 48'(dsel2), 48'(6'b000001));
         end
      end
      check("tbl_all_probed", 48'(p), 48'(14));

      // Dim: only c in [4,32) with c%16 <= 3 drives, i.e. c = 16..19
      restart();
      brightness = 4'd3;
      cnt = 0;
      for (int k = 0; k < P; k++) begin
         step();
         if (dsel != 6'h3F) cnt++;
      end
      check("dim_slot0_count", 48'(cnt), 48'(4));
      cnt = 0;
      for (int k = 0; k < P; k++) begin
         step();
         if (dsel != 6'h3F) cnt++;
         if (k == 10) brightness = 4'd15;
      end
      check("dim_midslot_change_count", 48'(cnt), 48'(4));
      cnt = 0;
      for (int k = 0; k < P; k++) begin
         step();
         if (dsel != 6'h3F) cnt++;
      end
      check("bright_next_slot_count", 48'(cnt), 48'(28));

      // Tear-free capture: new codes written mid-frame
      restart();
      segs_in = {G_C, G_H, G_I, G_P, G_BL, G_BL};
      for (int t = 0; t <= 300; t++) begin
         step();
         if (t == 70) segs_in = {G_BL, G_BL, G_C, G_H, G_I, G_P};
         if (t == 100) check("tear_old_seg", 48'(seg), 48'(G_I));
         if (t == 192) check("tear_frame_start", 48'(fs), 48'(1'b1));
         if (t == 196) check("tear_new_digit0", 48'(seg), 48'(G_P));
         if (t == 292) check("tear_new_digit3", 48'(seg), 48'(G_C));
      end

      // Enable drop while a digit is driven
      restart();
      for (int t = 0; t < 50; t++) step();
      check("pre_drop_driven", 48'(dsel), 48'(6'h3D));
      enable = 1'b0;
      step();
      check("drop_seg", 48'(seg), 48'(8'hFF));
      check("drop_digit_sel", 48'(dsel), 48'(6'h3F));
      enable = 1'b1;
      step();
      check("reenable_frame_start", 48'(fs), 48'(1'b1));
      for (int t = 1; t <= 4; t++) step();
      check("reenable_slot0", 48'(dsel), 48'(6'h3E));

      // Asynchronous reset mid-frame
      for (int t = 5; t < 40; t++) step();
      check("pre_reset_driven", 48'(dsel), 48'(6'h3D));
      reset_n = 1'b0;
      #1;
      check("async_reset_seg", 48'(seg), 48'(8'hFF));
      check("async_reset_digit_sel", 48'(dsel), 48'(6'h3F));
      check("async_reset_pol_seg", 48'(seg2), 48'(8'h00));
      step();
      step();
      reset_n = 1'b1;
      step();
      check("post_reset_capture", 48'(fs), 48'(1'b1));

      // Randomized run, checked every cycle by the model
      for (int k = 0; k < 1500; k++) begin
         step();
         if ($urandom_range(0, 199) == 0) enable = 1'b0;
         else if (!enable && $urandom_range(0, 3) == 0) enable = 1'b1;
         if ($urandom_range(0, 39) == 0) brightness = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 49) == 0) segs_in = {16'($urandom), $urandom};
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
